uart_tx_bus: RTL

- Bus-mapped UART transmitter, the transmit-side counterpart of the bus UART receiver on the same peripheral bus.
- Serialises a 1..32-bit word LSB-first on `tx`: start bit, data, optional parity, one stop bit.
- Baud rate comes from a fractional accumulator programmed with the same `dven`/`dvsr` register pair as the receiver.
- Provides a 1-deep holding buffer and an idle interrupt.

---
 rtl/uart_tx_pkg.sv | 49 ++++
 rtl/uart_baud_acc.sv | 45 ++++
 rtl/uart_tx_bus.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the bus-mapped UART transmitter.
//   - register word offsets (decoded on addr & ~3)
//   - CTRL/STAT bit positions
//   - transmitter state enum
//   - parity mode encodings and helpers
package uart_tx_pkg;

  localparam logic [31:0] ADDR_DATA = 32'h0000_0000;
  localparam logic [31:0] ADDR_DVEN = 32'h0000_0004;
  localparam logic [31:0] ADDR_DVSR = 32'h0000_0008;
  localparam logic [31:0] ADDR_CTRL = 32'h0000_000C;

  localparam int unsigned CTRL_IDX_LSB    = 0;
  localparam int unsigned CTRL_WIDTH_LSB  = 6;
  localparam int unsigned CTRL_IDLE       = 12;
  localparam int unsigned CTRL_IRQ_EN     = 13;
  localparam int unsigned CTRL_IRQ_STATUS = 14;
  localparam int unsigned CTRL_IRQ_UNMASK = 15;
  localparam int unsigned CTRL_FULL       = 16;
  localparam int unsigned CTRL_OVERRUN    = 17;
  localparam int unsigned CTRL_PARITY_LSB = 18;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Mode 11 is reserved and behaves like "none".
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

  // Parity over the low w bits of d; widths above 32 cover the whole word.
  function automatic logic parity_bit(input logic [31:0] d, input logic [5:0] w,
                                      input logic [1:0] mode);
    logic [31:0] mask;
    if (w >= 6'd32) mask = '1;
    else            mask = (32'd1 << w) - 32'd1;
    return (^(d & mask)) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_acc.sv
// uart_baud_acc: fractional baud accumulator. Adds dvsr each enabled cycle and
// emits tick whenever the sum reaches dven, so a bit lasts dven/dvsr cycles on average.
// Ports:
//   clk, rstb  clock, asynchronous active-low reset
//   dven       divider denominator
//   dvsr       divider numerator (0 stalls ticks)
//   clr        zero the accumulator (has priority over en)
//   en         accumulate this cycle
//   tick       combinational baud tick, valid while en
module uart_baud_acc (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] dven,
  input  logic [31:0] dvsr,
  input  logic        clr,
  input  logic        en,
  output logic        tick
);

  logic [31:0] acc_q, acc_d;
  logic [32:0] sum;

  always_comb begin
    // 33-bit sum so large divider values cannot wrap the compare.
    sum   = {1'b0, acc_q} + {1'b0, dvsr};
    tick  = 1'b0;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      if (sum >= {1'b0, dven}) begin
        tick  = 1'b1;
        acc_d = 32'(sum - {1'b0, dven});
      end else begin
        acc_d = sum[31:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_tx_bus.sv
// uart_tx_bus: bus-mapped UART transmitter with a 1-deep holding buffer and idle interrupt.
// Frame on tx: start bit, 1..32 data bits LSB first, optional parity, one stop bit.
// Optional parity is compiled in with the UART_TX_PARITY_EN macro.
// Ports:
//   clk, rstb  clock, asynchronous active-low reset
//   tx         serial line, idles high
//   irq        irq_unmask & irq_status
//   ready      registered copy of valid
//   rdata      registered read data, right-shifted by 8*addr[1:0]
//   wdata      write data, left-shifted by 8*addr[1:0] before use
//   write      1 = write access
//   addr       byte address, decoded on addr & ~3
//   size       access size (not decoded)
//   valid      access strobe
module uart_tx_bus
  import uart_tx_pkg::*;
#(
  parameter logic [31:0] DVEN_RST  = 32'd24,
  parameter logic [31:0] DVSR_RST  = 32'd2,
  parameter logic [5:0]  WIDTH_RST = 6'd8
) (
  input  logic        clk,
  input  logic        rstb,
  output logic        tx,
  output logic        irq,
  output logic        ready,
  output logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        valid
);

  logic unused_size;
  assign unused_size = ^size;

  state_e      state_q, state_d;
  logic [31:0] dven_q, dven_d, dvsr_q, dvsr_d, data_q, data_d, shift_q, shift_d;
  logic [31:0] rdata_q, rdata_d;
  logic [5:0]  width_q, width_d, fwidth_q, fwidth_d, idx_q, idx_d;
  logic        full_q, full_d, overrun_q, overrun_d, ready_q;
  logic        irq_en_q, irq_en_d, irq_status_q, irq_status_d, irq_unmask_q, irq_unmask_d;
  logic        idle_q, par_on_q, par_on_d, par_bit_q, par_bit_d;
  logic        tick, consume, idle;
  logic [1:0]  par_mode;
  logic [31:0] wd, word_addr, ctrl_rd;
  logic [4:0]  shamt;
  logic        wr, rd;

  assign shamt     = {addr[1:0], 3'b000};
  assign wd        = wdata << shamt;
  assign word_addr = addr & ~32'd3;
  assign wr        = valid & write;
  assign rd        = valid & ~write;

`ifdef UART_TX_PARITY_EN
  logic [1:0] par_mode_q, par_mode_d;
  always_comb begin
    par_mode_d = par_mode_q;
    if (wr && word_addr == ADDR_CTRL) par_mode_d = wd[CTRL_PARITY_LSB +: 2];
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) par_mode_q <= PAR_NONE;
    else       par_mode_q <= par_mode_d;
  end
  assign par_mode = par_mode_q;
`else
  assign par_mode = PAR_NONE;
`endif

  uart_baud_acc u_baud (
    .clk  (clk),
    .rstb (rstb),
    .dven (dven_q),
    .dvsr (dvsr_q),
    .clr  (consume && state_q == StIdle),
    .en   (state_q != StIdle),
    .tick (tick)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // FSM next state; consume marks the buffer being moved into the shifter.
  always_comb begin
    state_d = state_q;
    consume = 1'b0;
    unique case (state_q)
      StIdle: if (full_q && width_q != 6'd0) begin
        consume = 1'b1;
        state_d = StStart;
      end
      StStart:  if (tick) state_d = StData;
      StData:   if (tick && idx_q == fwidth_q - 6'd1) state_d = par_on_q ? StParity : StStop;
      StParity: if (tick) state_d = StStop;
      StStop: if (tick) begin
        if (full_q && width_q != 6'd0) begin
          consume = 1'b1;
          state_d = StStart;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    unique case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = shift_q[0];
      StParity: tx = par_bit_q;
      default:  tx = 1'b1;
    endcase
    idle = (state_q == StIdle) && !full_q;
  end

  assign irq   = irq_unmask_q & irq_status_q;
  assign ready = ready_q;
  assign rdata = rdata_q;

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[CTRL_IDX_LSB +: 6]      = idx_q;
    ctrl_rd[CTRL_WIDTH_LSB +: 6]    = width_q;
    ctrl_rd[CTRL_IDLE]              = idle;
    ctrl_rd[CTRL_IRQ_EN]            = irq_en_q;
    ctrl_rd[CTRL_IRQ_STATUS]        = irq_status_q;
    ctrl_rd[CTRL_IRQ_UNMASK]        = irq_unmask_q;
    ctrl_rd[CTRL_FULL]              = full_q;
    ctrl_rd[CTRL_OVERRUN]           = overrun_q;
    ctrl_rd[CTRL_PARITY_LSB +: 2]   = par_mode;

    rdata_d = '0;
    if (rd) begin
      case (word_addr)
        ADDR_DATA: rdata_d = data_q >> shamt;
        ADDR_DVEN: rdata_d = dven_q >> shamt;
        ADDR_DVSR: rdata_d = dvsr_q >> shamt;
        ADDR_CTRL: rdata_d = ctrl_rd >> shamt;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    dven_d       = dven_q;
    dvsr_d       = dvsr_q;
    width_d      = width_q;
    irq_en_d     = irq_en_q;
    irq_unmask_d = irq_unmask_q;
    irq_status_d = irq_status_q;
    overrun_d    = overrun_q;
    data_d       = data_q;
    full_d       = full_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    fwidth_d     = fwidth_q;
    par_on_d     = par_on_q;
    par_bit_d    = par_bit_q;

    if (wr && word_addr == ADDR_DVEN) dven_d = wd;
    if (wr && word_addr == ADDR_DVSR) dvsr_d = wd;
    if (wr && word_addr == ADDR_CTRL) begin
      width_d      = wd[CTRL_WIDTH_LSB +: 6];
      irq_en_d     = wd[CTRL_IRQ_EN];
      irq_unmask_d = wd[CTRL_IRQ_UNMASK];
      if (wd[CTRL_IRQ_STATUS]) irq_status_d = 1'b0;
      if (wd[CTRL_OVERRUN])    overrun_d    = 1'b0;
    end

    // Sets come after the clears so a same-cycle set wins.
    if (irq_en_q && idle && !idle_q) irq_status_d = 1'b1;

    if (consume) begin
      full_d    = 1'b0;
      shift_d   = data_q;
      idx_d     = '0;
      fwidth_d  = width_q;
      par_on_d  = parity_on(par_mode);
      par_bit_d = parity_bit(data_q, width_q, par_mode);
    end else if (state_q == StData && tick) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + 6'd1;
    end

    // A write landing on the consume cycle refills the buffer.
    if (wr && word_addr == ADDR_DATA) begin
      if (!full_q || consume) begin
        data_d = wd;
        full_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dven_q       <= DVEN_RST;
      dvsr_q       <= DVSR_RST;
      width_q      <= WIDTH_RST;
      irq_en_q     <= 1'b0;
      irq_unmask_q <= 1'b0;
      irq_status_q <= 1'b0;
      overrun_q    <= 1'b0;
      data_q       <= '0;
      full_q       <= 1'b0;
      shift_q      <= '0;
      idx_q        <= '0;
      fwidth_q     <= WIDTH_RST;
      par_on_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      idle_q       <= 1'b1;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
    end else begin
      dven_q       <= dven_d;
      dvsr_q       <= dvsr_d;
      width_q      <= width_d;
      irq_en_q     <= irq_en_d;
      irq_unmask_q <= irq_unmask_d;
      irq_status_q <= irq_status_d;
      overrun_q    <= overrun_d;
      data_q       <= data_d;
      full_q       <= full_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      fwidth_q     <= fwidth_d;
      par_on_q     <= par_on_d;
      par_bit_q    <= par_bit_d;
      idle_q       <= idle;
      ready_q      <= valid;
      rdata_q      <= rdata_d;
    end
  end

endmodule
